crumb_sched: RTL and testbench
==============================

Name: crumb_sched

Overview:
Controller that sequences a chain of N crumb stages. It issues an active-low clear to the chain, then drives a one-hot round-robin enable across the stages for a programmed number of rounds. An internal 16-bit LFSR supplies the two random-bit inputs shared by every stage. The block sits between the top-level control and the crumb array, and exposes a start/busy/done handshake.

Parameters:
N, 4, number of crumb stages driven (2..16)
RW, 8, width of the rounds count
CLR_CYCLES, 2, cycles the crumb clear is held low (>=1)
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled in IDLE only
stop  in  1  abort the run; sampled in CLR and RUN
rounds  in  RW  full passes over all N stages; captured on accepted start
crumb_rst_n  out  1  active-low clear to all crumb stages
crumb_en  out  N  one-hot stage enable
rbit  out  1  random bit 1 to stages (lfsr[0])
rbit2  out  1  random bit 2 to stages (lfsr[8])
busy  out  1  high in CLR and RUN
done  out  1  one-cycle completion pulse
stage_idx  out  $clog2(N)  current stage index
round_cnt  out  RW  completed rounds

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- All outputs except rbit/rbit2 are registered. rbit/rbit2 are decoded directly from the LFSR register.
- Reset values: state=IDLE, crumb_rst_n=1, crumb_en=0, busy=0, done=0, stage_idx=0, round_cnt=0, lfsr=SEED (or 16'hACE1 if SEED==0).
- IDLE:
  - outputs quiescent.
  - start=1 with rounds!=0 -> capture rounds; go CLR; clear stage_idx and round_cnt.
  - start=1 with rounds==0 -> go DONE directly; no clear, no enables.
- CLR:
  - crumb_rst_n=0 for exactly CLR_CYCLES cycles, then go RUN.
  - crumb_en=0 throughout.
- RUN:
  - each cycle crumb_en = 1<<stage_idx.
  - stage_idx increments each cycle and wraps N-1 -> 0.
  - at the wrap, round_cnt increments.
  - when the incremented round_cnt equals the captured rounds, go DONE on the next edge.
- DONE:
  - done=1, busy=0, crumb_en=0 for one cycle, then IDLE.
  - round_cnt and stage_idx hold their final values until the next accepted start.
- stop in CLR or RUN:
  - next cycle is DONE; crumb_en=0 and crumb_rst_n=1 from that cycle.
  - round_cnt is frozen at its current value; no partial-round increment.
- Simultaneous stop with the final wrap: one DONE cycle only; round_cnt equals rounds.
- start while busy or in DONE: ignored.
- LFSR:
  - Fibonacci form, x^16+x^14+x^13+x^11+1.
  - fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
  - advances only in cycles where crumb_en != 0.
  - holds its value across runs and is not reloaded by start.
- rst asserted at any time (mid-CLR, mid-RUN) -> reset values next edge. No done pulse is produced.
- Latency: start accepted at edge k gives first crumb_en at cycle k+1+CLR_CYCLES. Total run length is CLR_CYCLES + N*rounds cycles, plus 1 DONE cycle.

Optional Feature:
Macro CRUMB_SCHED_RESEED_EN.
- Defined: adds ports reseed (in, 1) and seed_in (in, 16).
  - reseed=1 in IDLE loads lfsr <= (seed_in==0 ? 16'hACE1 : seed_in) on the next edge.
  - reseed is ignored outside IDLE.
  - if start and reseed are high together, both act: the seed loads and the run begins.
- Undefined: neither port exists; the LFSR changes only by reset or by advancing.

Test Plan:
- N=4, CLR_CYCLES=2, rounds=2, start pulse at cycle 0 -> crumb_rst_n=0 in cycles 1-2; crumb_en=0001,0010,0100,1000 twice in cycles 3-10; done=1 in cycle 11; round_cnt=2; busy high cycles 1-10.
- After reset, first RUN cycle -> rbit=1, rbit2=0 (lfsr=ACE1); second RUN cycle -> lfsr=5670, rbit=0, rbit2=0; LFSR unchanged during CLR.
- rounds=0, start -> done=1 the cycle after start; crumb_en never nonzero; crumb_rst_n stays 1.
- rounds=3, stop asserted on the 6th RUN cycle (stage_idx=1, round 1) -> next cycle DONE with crumb_en=0; round_cnt=1; then IDLE.
- rst pulse in the middle of RUN -> next cycle all outputs at reset values, lfsr=ACE1, no done pulse; a start pulse during busy is ignored (run length unchanged).
- With CRUMB_SCHED_RESEED_EN: reseed=1, seed_in=0 in IDLE -> lfsr=ACE1; seed_in=16'h0001 -> the first RUN cycle gives rbit=1, rbit2=0.

Source files
------------

// File: rtl/crumb_sched.sv
// -----------------------------------------------------------------------------
// crumb_sched
//
// This block sequences a chain of N crumb stages. A run has up to three parts:
//   - CLR:  the active-low clear is held low for CLR_CYCLES cycles.
//   - RUN:  a one-hot enable steps round-robin over the stages for the
//           captured number of full rounds.
//   - DONE: a single-cycle completion pulse.
// A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) supplies two random bits
// that every stage shares. The LFSR advances only in cycles where an enable
// is active.
//
// Optional build macro: CRUMB_SCHED_RESEED_EN. It adds the reseed/seed_in
// ports, which reload the LFSR while the block is idle.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a run (sampled in IDLE only)
//   stop           abort the run (sampled in CLR and RUN)
//   rounds         number of full passes, captured when start is accepted
//   crumb_rst_n    active-low clear to the stages (registered)
//   crumb_en       one-hot stage enable (registered)
//   rbit, rbit2    random bits, lfsr[0] and lfsr[8]
//   busy, done     high in CLR/RUN; one-cycle completion pulse
//   stage_idx      index of the stage enabled this cycle
//   round_cnt      completed rounds
//   reseed/seed_in (optional) load a new LFSR value while idle
// -----------------------------------------------------------------------------
module crumb_sched #(
    parameter int          N          = 4,
    parameter int          RW         = 8,
    parameter int          CLR_CYCLES = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [RW-1:0]        rounds,
    output logic                 crumb_rst_n,
    output logic [N-1:0]         crumb_en,
    output logic                 rbit,
    output logic                 rbit2,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] stage_idx,
    output logic [RW-1:0]        round_cnt
`ifdef CRUMB_SCHED_RESEED_EN
    ,
    input  logic                 reseed,
    input  logic [15:0]          seed_in
`endif
);

    localparam int              SW         = $clog2(N);
    localparam int              CW         = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0]   CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [SW-1:0]   STAGE_LAST = SW'(N - 1);
    // An all-zero LFSR would lock up, so a zero seed falls back to ACE1.
    localparam logic [15:0]     SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [RW-1:0]   rounds_q, rounds_d;
    logic [SW-1:0]   stage_idx_q, stage_idx_d;
    logic [RW-1:0]   round_cnt_q, round_cnt_d;
    logic            crumb_rst_n_q, crumb_rst_n_d;
    logic [N-1:0]    crumb_en_q, crumb_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [N-1:0]    en_dec;

    // One-hot decode of the stage index that will be current next cycle.
    for (genvar gi = 0; gi < N; gi++) begin : g_en_dec
        assign en_dec[gi] = (stage_idx_d == SW'(gi));
    end

    // Next-state logic. The registered outputs are derived from the state
    // being entered, so they line up with that state in the following cycle.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        rounds_d      = rounds_q;
        stage_idx_d   = stage_idx_q;
        round_cnt_d   = round_cnt_q;
        crumb_rst_n_d = 1'b1;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        crumb_en_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rounds_d    = rounds;
                    stage_idx_d = '0;
                    round_cnt_d = '0;
                    clr_cnt_d   = '0;
                    state_d     = (rounds != '0) ? S_CLR : S_DONE;
                end
            end
            S_CLR: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (stage_idx_q == STAGE_LAST) begin
                    // The final wrap completes the run even if stop arrives
                    // in the same cycle, so round_cnt always reaches rounds.
                    if (round_cnt_q + RW'(1) == rounds_q) begin
                        stage_idx_d = '0;
                        round_cnt_d = round_cnt_q + RW'(1);
                        state_d     = S_DONE;
                    end else if (stop) begin
                        state_d = S_DONE;
                    end else begin
                        stage_idx_d = '0;
                        round_cnt_d = round_cnt_q + RW'(1);
                    end
                end else if (stop) begin
                    state_d = S_DONE;
                end else begin
                    stage_idx_d = stage_idx_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_CLR: begin
                crumb_rst_n_d = 1'b0;
                busy_d        = 1'b1;
            end
            S_RUN: begin
                busy_d     = 1'b1;
                crumb_en_d = en_dec;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The LFSR steps once for every enabled stage cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (crumb_en_q != '0) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
`ifdef CRUMB_SCHED_RESEED_EN
        if (state_q == S_IDLE && reseed) begin
            lfsr_d = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            rounds_q      <= '0;
            stage_idx_q   <= '0;
            round_cnt_q   <= '0;
            crumb_rst_n_q <= 1'b1;
            crumb_en_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lfsr_q        <= SEED_EFF;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            rounds_q      <= rounds_d;
            stage_idx_q   <= stage_idx_d;
            round_cnt_q   <= round_cnt_d;
            crumb_rst_n_q <= crumb_rst_n_d;
            crumb_en_q    <= crumb_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign crumb_rst_n = crumb_rst_n_q;
    assign crumb_en    = crumb_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stage_idx   = stage_idx_q;
    assign round_cnt   = round_cnt_q;
    assign rbit        = lfsr_q[0];
    assign rbit2       = lfsr_q[8];

endmodule

// File: tb/tb_crumb_sched.sv
// -----------------------------------------------------------------------------
// tb_crumb_sched
//
// This bench runs directed and random stimulus against crumb_sched
// (N=4, CLR_CYCLES=2). For every run it derives the whole expected cycle
// timeline from the run's length rules: clear cycles, then N*rounds enable
// cycles, then the DONE cycle. It tracks the LFSR as a 16-bit value that
// steps once per enabled cycle.
// -----------------------------------------------------------------------------
module tb_crumb_sched;
    localparam int N  = 4;
    localparam int RW = 8;
    localparam int C  = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [RW-1:0] rounds;
    logic          crumb_rst_n;
    logic [N-1:0]  crumb_en;
    logic          rbit;
    logic          rbit2;
    logic          busy;
    logic          done;
    logic [1:0]    stage_idx;
    logic [RW-1:0] round_cnt;
`ifdef CRUMB_SCHED_RESEED_EN
    logic          reseed;
    logic [15:0]   seed_in;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;

    crumb_sched #(.N(N), .RW(RW), .CLR_CYCLES(C), .SEED(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .rounds      (rounds),
        .crumb_rst_n (crumb_rst_n),
        .crumb_en    (crumb_en),
        .rbit        (rbit),
        .rbit2       (rbit2),
        .busy        (busy),
        .done        (done),
        .stage_idx   (stage_idx),
        .round_cnt   (round_cnt)
`ifdef CRUMB_SCHED_RESEED_EN
        ,
        .reseed      (reseed),
        .seed_in     (seed_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1, shifted right with feedback into bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
            $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int e_rst_n, input int e_en, input int e_busy,
                                 input int e_done, input int e_stage, input int e_round);
        check("crumb_rst_n", 32'(crumb_rst_n), 32'(e_rst_n));
        check("crumb_en",    32'(crumb_en),    32'(e_en));
        check("busy",        32'(busy),        32'(e_busy));
        check("done",        32'(done),        32'(e_done));
        check("stage_idx",   32'(stage_idx),   32'(e_stage));
        check("round_cnt",   32'(round_cnt),   32'(e_round));
        check("rbit",        32'(rbit),        32'(m_lfsr[0]));
        check("rbit2",       32'(rbit2),       32'(m_lfsr[8]));
    endtask

    // One complete run, starting from IDLE. stop_t is the cycle after the
    // start (counting from 1) during which stop is held high; -1 means none.
    // poke drives extra start pulses while busy and during DONE. Those pulses
    // must be ignored.
    task automatic do_run(input int r, input int stop_t_in, input bit poke);
        int stop_t, done_t, fin_round, fin_stage, j;
        int e_rst_n, e_en, e_busy, e_done, e_stage, e_round;
        stop_t    = (r > 0 && stop_t_in >= 1 && stop_t_in <= C + N * r) ? stop_t_in : -1;
        done_t    = (r == 0) ? 1 : C + N * r + 1;
        fin_round = r;
        fin_stage = 0;
        if (stop_t > 0) begin
            done_t = stop_t + 1;
            if (stop_t <= C) begin
                fin_round = 0;
            end else begin
                j = stop_t - C - 1;
                if (j != N * r - 1) begin
                    fin_round = j / N;
                    fin_stage = j % N;
                end
            end
        end
        $display("run rounds=%0d stop_cycle=%0d poke=%0d done_cycle=%0d final_round=%0d",
                 r, stop_t, poke, done_t, fin_round);

        @(negedge clk);
        start  = 1'b1;
        rounds = 8'(r);
        for (int t = 1; t <= done_t + 1; t++) begin
            @(negedge clk);
            if (t < done_t) begin
                e_busy = 1;
                e_done = 0;
                if (t <= C) begin
                    e_rst_n = 0; e_en = 0; e_stage = 0; e_round = 0;
                end else begin
                    j       = t - C - 1;
                    e_rst_n = 1;
                    e_en    = 1 << (j % N);
                    e_stage = j % N;
                    e_round = j / N;
                end
            end else begin
                e_busy  = 0;
                e_rst_n = 1;
                e_en    = 0;
                e_stage = fin_stage;
                e_round = fin_round;
                e_done  = (t == done_t) ? 1 : 0;
            end
            check_outputs(e_rst_n, e_en, e_busy, e_done, e_stage, e_round);
            if (e_en != 0) m_lfsr = lfsr_step(m_lfsr);
            start = poke && ((t == 2 && t < done_t) || t == done_t);
            stop  = (t == stop_t);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int r, st;
        bit pk;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        rounds = '0;
`ifdef CRUMB_SCHED_RESEED_EN
        reseed  = 1'b0;
        seed_in = 16'h0000;
`endif
        m_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);
        $display("reset check");
        check_outputs(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_outputs(1, 0, 0, 0, 0, 0);

        // Directed runs: two full rounds, zero rounds, and a stop in round 1.
        do_run(2, -1, 1'b0);
        do_run(0, -1, 1'b1);
        do_run(3, C + 6, 1'b0);

        // Reset in the middle of RUN, with a stray start pulse while busy.
        $display("reset mid-run");
        @(negedge clk);
        start  = 1'b1;
        rounds = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (C + 2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        m_lfsr = 16'hACE1;
        check_outputs(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_outputs(1, 0, 0, 0, 0, 0);

`ifdef CRUMB_SCHED_RESEED_EN
        $display("reseed zero");
        reseed  = 1'b1;
        seed_in = 16'h0000;
        @(negedge clk);
        reseed = 1'b0;
        m_lfsr = 16'hACE1;
        check("reseed0_rbit",  32'(rbit),  32'(m_lfsr[0]));
        check("reseed0_rbit2", 32'(rbit2), 32'(m_lfsr[8]));
        $display("reseed one");
        reseed  = 1'b1;
        seed_in = 16'h0001;
        @(negedge clk);
        reseed = 1'b0;
        m_lfsr = 16'h0001;
        check("reseed1_rbit",  32'(rbit),  32'(1));
        check("reseed1_rbit2", 32'(rbit2), 32'(0));
        do_run(1, -1, 1'b0);
`endif

        // Random runs, some with stops and stray start pulses.
        for (int k = 0; k < 12; k++) begin
            r  = int'($urandom_range(0, 4));
            st = -1;
            if (r > 0 && $urandom_range(0, 1) == 1) st = int'($urandom_range(1, C + N * r));
            pk = 1'($urandom_range(0, 1));
            do_run(r, st, pk);
            repeat (int'($urandom_range(0, 2))) begin
                @(negedge clk);
                check("idle_busy", 32'(busy), 32'(0));
                check("idle_done", 32'(done), 32'(0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
